// File: rtl/prog_sequencer_pkg.sv
// prog_sequencer_pkg
// Shared definitions for the program sequencer: the FSM state type, the
// table of program entry points, and helpers for looking up a program's
// base address and stepping to the next program index.
package prog_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seqState_e;

  localparam int NUM_PROGS = 3;
  localparam int BASE_W    = 10;

  localparam logic [1:0] LAST_IDX = 2'(NUM_PROGS - 1);

  // Entry 0 sits in the low slice, entry 2 in the high slice.
  localparam logic [NUM_PROGS-1:0][BASE_W-1:0] PROG_BASE = {
    10'h200, 10'h100, 10'h000
  };

  // Unused index 3 falls back to program 0 so the lookup is always defined.
  function automatic logic [BASE_W-1:0] progBase(input logic [1:0] idx);
    case (idx)
      2'd1:    return PROG_BASE[1];
      2'd2:    return PROG_BASE[2];
      default: return PROG_BASE[0];
    endcase
  endfunction

  function automatic logic [1:0] nextIdx(input logic [1:0] idx);
    return (idx >= LAST_IDX) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/prog_sequencer_sat.sv
// sat_counter
// Up-counter with synchronous clear and count enable that sticks at
// all-ones instead of wrapping.
// Ports:
//   Clk      - clock, rising edge
//   Reset    - synchronous, active-high, clears the count
//   clear_i  - clear the count to zero (wins over enable)
//   enable_i - advance the count by one
//   count_o  - current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear_i,
  input  logic         enable_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer
// Steps the fetch unit through a fixed rotation of three programs. Each Go
// request in IDLE loads the next program's entry point into the fetch unit,
// lets it run until the decoder reports a halt or a watchdog expires, then
// emits a one-cycle Done pulse and advances to the next program.
// Ports:
//   Clk, Reset   - clock and synchronous active-high reset
//   Go           - start the next program (sampled in IDLE only)
//   HaltSeen     - decoder saw a halt instruction (sampled in RUN only)
//   FetchHold    - hold the fetch PC (IDLE and DONE)
//   FetchJump    - absolute branch strobe for the fetch unit (LOAD only)
//   FetchTarget  - branch target, the program base during LOAD, else 0
//   ProgIdx      - index of the current/next program, 0..2
//   Busy         - high while a program is loading or running
//   Done         - one-cycle completion pulse
//   Timeout      - program ended by watchdog rather than halt
//   CycleCount   - RUN cycles spent by the current/last program
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int               PC_W        = 10,
  parameter int               CYC_W       = 16,
  parameter logic [CYC_W-1:0] CYCLE_LIMIT = 16'hFFF0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             HaltSeen,
  output logic             FetchHold,
  output logic             FetchJump,
  output logic [PC_W-1:0]  FetchTarget,
  output logic [1:0]       ProgIdx,
  output logic             Busy,
  output logic             Done,
  output logic             Timeout,
  output logic [CYC_W-1:0] CycleCount
);

  localparam logic [CYC_W-1:0] LIMIT_M1 = CYCLE_LIMIT - CYC_W'(1);

  seqState_e  state_q;
  logic [1:0] progIdx_q;
  logic       timeout_q;
  logic [CYC_W-1:0] cycleCount;

  // The count is compared before its own increment, so the watchdog exit
  // edge is also the CYCLE_LIMIT-th counted RUN cycle.
  sat_counter #(
    .W (CYC_W)
  ) u_cycleCounter (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear_i  (state_q == LOAD),
    .enable_i (state_q == RUN),
    .count_o  (cycleCount)
  );

  // Halt is tested ahead of the watchdog so a halt on the limit cycle is
  // reported as a normal completion.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      progIdx_q <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Go) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          timeout_q <= 1'b0;
          state_q   <= RUN;
        end
        RUN: begin
          if (HaltSeen) begin
            timeout_q <= 1'b0;
            state_q   <= DONE;
          end else if (cycleCount == LIMIT_M1) begin
            timeout_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          progIdx_q <= nextIdx(progIdx_q);
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign FetchHold   = (state_q == IDLE) || (state_q == DONE);
  assign FetchJump   = (state_q == LOAD);
  assign FetchTarget = (state_q == LOAD) ? PC_W'(progBase(progIdx_q)) : '0;
  assign ProgIdx     = progIdx_q;
  assign Busy        = (state_q == LOAD) || (state_q == RUN);
  assign Done        = (state_q == DONE);
  assign Timeout     = timeout_q;
  assign CycleCount  = cycleCount;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer
// Drives the sequencer one cycle at a time. Each driven cycle advances a
// small reference model of the sequencer and pushes the outputs it expects
// after that edge onto a scoreboard queue; just after the edge the head of
// the queue is popped and compared with the DUT.
module tb_prog_sequencer;

  localparam int LIMIT = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Go;
  logic        HaltSeen;
  logic        FetchHold;
  logic        FetchJump;
  logic [9:0]  FetchTarget;
  logic [1:0]  ProgIdx;
  logic        Busy;
  logic        Done;
  logic        Timeout;
  logic [15:0] CycleCount;

  typedef struct packed {
    logic        hold;
    logic        jump;
    logic [9:0]  target;
    logic [1:0]  idx;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] count;
  } exp_t;

  exp_t expQ[$];

  // Reference model: 0=IDLE 1=LOAD 2=RUN 3=DONE
  int          mState = 0;
  logic [1:0]  mIdx   = 2'd0;
  logic [15:0] mCnt   = 16'd0;
  logic        mTo    = 1'b0;

  int passCount  = 0;
  int checkCount = 0;
  int cycle      = 0;

  prog_sequencer #(
    .PC_W        (10),
    .CYC_W       (16),
    .CYCLE_LIMIT (16'(LIMIT))
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Go          (Go),
    .HaltSeen    (HaltSeen),
    .FetchHold   (FetchHold),
    .FetchJump   (FetchJump),
    .FetchTarget (FetchTarget),
    .ProgIdx     (ProgIdx),
    .Busy        (Busy),
    .Done        (Done),
    .Timeout     (Timeout),
    .CycleCount  (CycleCount)
  );

  // Free-running 10 ns clock
  always #5 Clk = ~Clk;

  // Hard stop in case the stimulus never finishes
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish expected finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [9:0] expBase(input logic [1:0] idx);
    case (idx)
      2'd1:    return 10'h100;
      2'd2:    return 10'h200;
      default: return 10'h000;
    endcase
  endfunction

  function automatic exp_t modelOutputs();
    exp_t e;
    e.hold    = (mState == 0) || (mState == 3);
    e.jump    = (mState == 1);
    e.target  = (mState == 1) ? expBase(mIdx) : 10'h000;
    e.idx     = mIdx;
    e.busy    = (mState == 1) || (mState == 2);
    e.done    = (mState == 3);
    e.timeout = mTo;
    e.count   = mCnt;
    return e;
  endfunction

  task automatic stepModel(input logic go, input logic halt, input logic rst);
    logic atLimit;
    if (rst) begin
      mState = 0;
      mIdx   = 2'd0;
      mCnt   = 16'd0;
      mTo    = 1'b0;
    end else begin
      case (mState)
        0: if (go) mState = 1;
        1: begin
          mCnt   = 16'd0;
          mTo    = 1'b0;
          mState = 2;
        end
        2: begin
          atLimit = (mCnt == 16'(LIMIT - 1));
          if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
          if (halt) begin
            mTo    = 1'b0;
            mState = 3;
          end else if (atLimit) begin
            mTo    = 1'b1;
            mState = 3;
          end
        end
        default: begin
          mIdx   = (mIdx == 2'd2) ? 2'd0 : mIdx + 2'd1;
          mState = 0;
        end
      endcase
    end
  endtask

  task automatic compareHead();
    exp_t e;
    e = expQ.pop_front();
    checkOutput($sformatf("c%0d.hold", cycle),    32'(FetchHold),   32'(e.hold));
    checkOutput($sformatf("c%0d.jump", cycle),    32'(FetchJump),   32'(e.jump));
    checkOutput($sformatf("c%0d.target", cycle),  32'(FetchTarget), 32'(e.target));
    checkOutput($sformatf("c%0d.idx", cycle),     32'(ProgIdx),     32'(e.idx));
    checkOutput($sformatf("c%0d.busy", cycle),    32'(Busy),        32'(e.busy));
    checkOutput($sformatf("c%0d.done", cycle),    32'(Done),        32'(e.done));
    checkOutput($sformatf("c%0d.timeout", cycle), 32'(Timeout),     32'(e.timeout));
    checkOutput($sformatf("c%0d.count", cycle),   32'(CycleCount),  32'(e.count));
  endtask

  task automatic applyStimulus(input logic go, input logic halt, input logic rst);
    Go       = go;
    HaltSeen = halt;
    Reset    = rst;
    stepModel(go, halt, rst);
    expQ.push_back(modelOutputs());
    @(posedge Clk);
    #1;
    cycle++;
    compareHead();
  endtask

  // Go, LOAD (with a stray halt), nRun RUN cycles, DONE, one IDLE cycle.
  task automatic runProgram(input int nRun, input bit haltLast, input bit goNoise);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(goNoise, 1'b1, 1'b0);
    for (int i = 0; i < nRun; i++) begin
      applyStimulus(goNoise, haltLast && (i == nRun - 1), 1'b0);
    end
    applyStimulus(goNoise, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
  endtask

  // Scenario sequence
  initial begin
    Go       = 1'b0;
    HaltSeen = 1'b0;
    Reset    = 1'b1;
    @(negedge Clk);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    runProgram(5, 1'b1, 1'b0);
    runProgram(3, 1'b1, 1'b0);
    runProgram(2, 1'b1, 1'b0);
    runProgram(LIMIT, 1'b0, 1'b0);
    runProgram(LIMIT, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    runProgram(2, 1'b1, 1'b0);
    runProgram(LIMIT + 2, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have these parameters: PC_W, default 10, program-counter width; CYC_W, default 16, cycle-counter width; CYCLE_LIMIT, default 16'hFFF0, watchdog limit in RUN cycles.
REQ-002 Clk  input  1  clock; all state changes on rising edge only.
REQ-003 Reset  input  1  synchronous, active-high.
REQ-004 Go  input  1  request to run the next program; sampled only in IDLE.
REQ-005 HaltSeen  input  1  decoder flags a halt instruction in the current cycle.
REQ-006 FetchHold  output  1  drives the fetch unit's Start input (hold PC).
REQ-007 FetchJump  output  1  drives the fetch unit's absolute-branch input.
REQ-008 FetchTarget  output  PC_W  absolute target for the fetch unit.
REQ-009 ProgIdx  output  2  index of the current/next program, range 0..2.
REQ-010 Busy  output  1  high in LOAD and RUN.
REQ-011 Done  output  1  one-cycle completion pulse.
REQ-012 Timeout  output  1  qualifies Done; high when the program ended by watchdog.
REQ-013 CycleCount  output  CYC_W  number of RUN cycles of the current/last program.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN and DONE; all outputs are Moore (decoded from registered state plus registers).
REQ-015 IDLE: FetchHold=1, FetchJump=0, Busy=0; Go=1 at edge -> LOAD; otherwise stay.
REQ-016 LOAD (exactly 1 cycle): FetchHold=0, FetchJump=1, FetchTarget=PROG_BASE[ProgIdx], Busy=1; CycleCount cleared to 0; -> RUN.
REQ-017 Outside LOAD, FetchTarget SHALL be 0 and FetchJump SHALL be 0.
REQ-018 RUN: FetchHold=0, Busy=1; CycleCount increments by 1 each RUN cycle and saturates at all-ones.
REQ-019 In RUN, HaltSeen=1 -> DONE with Timeout register cleared to 0.
REQ-020 In RUN, HaltSeen=0 and CycleCount==CYCLE_LIMIT-1 at the edge -> DONE with Timeout set to 1.
REQ-021 When HaltSeen and the limit occur in the same cycle, halt SHALL win (Timeout=0).
REQ-022 DONE (exactly 1 cycle): Done=1, FetchHold=1, Busy=0; CycleCount frozen; -> IDLE; ProgIdx increments at the exit edge, wrapping 2 -> 0.
REQ-023 Timeout SHALL hold its value from DONE until the next LOAD, where it is cleared.
REQ-024 CycleCount SHALL hold its final value through DONE and IDLE until the next LOAD.
REQ-025 Go in LOAD, RUN or DONE SHALL be ignored (not queued).
REQ-026 HaltSeen outside RUN SHALL be ignored.
REQ-027 Latency: Go high at edge k gives LOAD during cycle k+1, and the fetch PC equals PROG_BASE at edge k+2.

Reset
REQ-028 Reset SHALL take priority over all inputs, including Go and HaltSeen in the same cycle.
REQ-029 After Reset: state=IDLE, ProgIdx=0, CycleCount=0, Timeout=0, Done=0, Busy=0, FetchHold=1, FetchJump=0, FetchTarget=0.
REQ-030 Reset asserted in any state, including mid-RUN, SHALL abort the program without a Done pulse.

Structure
REQ-031 A shared package SHALL hold the state enum type, PROG_BASE table (0: 10'h000, 1: 10'h100, 2: 10'h200) and NUM_PROGS=3.
REQ-032 The RUN cycle counter with clear, enable and saturation SHALL be a sub-module named sat_counter; all other logic stays in prog_sequencer.

Verification
REQ-033 Reset then Go pulse -> LOAD with FetchJump=1 and FetchTarget=10'h000; RUN next cycle; HaltSeen after 5 RUN cycles -> Done=1, Timeout=0, CycleCount=5, ProgIdx becomes 1.
REQ-034 Three back-to-back programs -> FetchTarget sequence 10'h000, 10'h100, 10'h200; fourth Go -> 10'h000 (wrap).
REQ-035 CYCLE_LIMIT=8 and no halt -> Done after 8 RUN cycles with Timeout=1 and CycleCount=8; Timeout cleared at the next LOAD.
REQ-036 HaltSeen coincident with the limit cycle -> Timeout=0; Go pulses during RUN -> no extra LOAD.
REQ-037 Reset at RUN cycle 3 -> IDLE next cycle, no Done, ProgIdx=0, CycleCount=0; Reset and Go together -> remains IDLE.
